// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: MMU width codes,
// controller state encoding and arbitration mode selectors.
package mem_access_ctrl_pkg;

  localparam logic [1:0] MMU_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MMU_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MMU_WIDTH_WORD = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    MAC_IDLE   = 2'd0,
    MAC_ACCESS = 2'd1,
    MAC_DONE   = 2'd2
  } mac_state_e;

  // Width of a channel index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_arbiter.sv
// Combinational requester arbiter: picks one asserted channel, either the
// lowest index (fixed) or the first at/after the rotating pointer (round-robin).
module mem_access_arbiter
  import mem_access_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int IDX_W    = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_valid,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  // Channel examined at search offset 'off'; rotates by the pointer in round-robin.
  function automatic logic [IDX_W-1:0] chan_at(input int unsigned off,
                                               input logic [IDX_W-1:0] ptr);
    int unsigned c;
    if (ARB_MODE == ARB_RR) c = (off + 32'(ptr)) % NUM_CH;
    else                    c = off;
    return IDX_W'(c);
  endfunction

  // First asserted channel in search order wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!o_any && i_valid[chan_at(i, i_ptr)]) begin
        o_any                    = 1'b1;
        o_idx                    = chan_at(i, i_ptr);
        o_grant[chan_at(i, i_ptr)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates NUM_CH requesters onto one MMU port,
// holds the latched request until mmu_mem_ready, then acks for one cycle.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (ACCESS timeout + rsp_err output).
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int MAX_WAIT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH-1:0]        req_signed,
  input  logic [2*NUM_CH-1:0]      req_width,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [DATA_W*NUM_CH-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ack,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     busy,
  input  logic                     mmu_mem_ready,
  input  logic [DATA_W-1:0]        mmu_data_out,
  output logic                     mmu_write_enable,
  output logic                     mmu_read_enable,
  output logic                     mmu_mem_signed_read,
  output logic [1:0]               mmu_mem_data_width,
  output logic [ADDR_W-1:0]        mmu_address,
  output logic [DATA_W-1:0]        mmu_data_in
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  output logic                     rsp_err
`endif
);

  localparam int IDX_W = idx_width(NUM_CH);

  mac_state_e          r_state, w_state_nxt;
  logic [NUM_CH-1:0]   r_ack, w_ack_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_we, w_we_nxt;
  logic                r_re, w_re_nxt;
  logic                r_sgn, w_sgn_nxt;
  logic [1:0]          r_wid, w_wid_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_din, w_din_nxt;
  logic [IDX_W-1:0]    r_gidx, w_gidx_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [NUM_CH-1:0]   w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_err, w_err_nxt;
`endif

  mem_access_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE),
    .IDX_W    (IDX_W)
  ) u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Next state and next values of every registered output / latch field.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_rdata_nxt = r_rdata;
    w_we_nxt    = r_we;
    w_re_nxt    = r_re;
    w_sgn_nxt   = r_sgn;
    w_wid_nxt   = r_wid;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
`ifdef MEM_ACCESS_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      MAC_IDLE: begin
        if (w_any) begin
          w_state_nxt = MAC_ACCESS;
          w_gidx_nxt  = w_idx;
          w_we_nxt    = req_write[w_idx];
          w_re_nxt    = ~req_write[w_idx];
          w_sgn_nxt   = req_signed[w_idx];
          w_wid_nxt   = req_width[int'(w_idx)*2 +: 2];
          w_addr_nxt  = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
          w_din_nxt   = req_write[w_idx] ? req_wdata[int'(w_idx)*DATA_W +: DATA_W] : '0;
          if (ARB_MODE == ARB_RR)
            w_ptr_nxt = (w_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      MAC_ACCESS: begin
        if (mmu_mem_ready) begin
          w_state_nxt     = MAC_DONE;
          w_we_nxt        = 1'b0;
          w_re_nxt        = 1'b0;
          w_ack_nxt[r_gidx] = 1'b1;
          if (r_re) w_rdata_nxt = mmu_data_out;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        // Counter already equal to MAX_WAIT means MAX_WAIT full ACCESS cycles elapsed.
        else if (r_cnt == MAX_WAIT_C) begin
          w_state_nxt       = MAC_DONE;
          w_we_nxt          = 1'b0;
          w_re_nxt          = 1'b0;
          w_ack_nxt[r_gidx] = 1'b1;
          w_rdata_nxt       = '0;
          w_err_nxt         = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      MAC_DONE: w_state_nxt = MAC_IDLE;
      default:  w_state_nxt = MAC_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != MAC_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= MAC_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Registered outputs, request latch and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_sgn   <= 1'b0;
      r_wid   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_ack   <= w_ack_nxt;
      r_rdata <= w_rdata_nxt;
      r_busy  <= w_busy_nxt;
      r_we    <= w_we_nxt;
      r_re    <= w_re_nxt;
      r_sgn   <= w_sgn_nxt;
      r_wid   <= w_wid_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  // ACCESS wait counter and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign rsp_err = r_err;
`endif

  assign req_ack             = r_ack;
  assign rsp_rdata           = r_rdata;
  assign busy                = r_busy;
  assign mmu_write_enable    = r_we;
  assign mmu_read_enable     = r_re;
  assign mmu_mem_signed_read = r_sgn;
  assign mmu_mem_data_width  = r_wid;
  assign mmu_address         = r_addr;
  assign mmu_data_in         = r_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: fixed-priority 2-channel instance (table vectors
// plus hand sequences) and round-robin 3-channel instance.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // fixed-priority instance signals
  logic [1:0]  f_valid = '0, f_write = '0, f_sgn = '0, f_ack;
  logic [3:0]  f_width = '0;
  logic [63:0] f_addr = '0, f_wdata = '0;
  logic [31:0] f_rdata, f_dout = '0, f_adr, f_din;
  logic        f_busy, f_ready = 1'b0, f_we, f_re, f_msgn;
  logic [1:0]  f_wid;
  // round-robin instance signals
  logic [2:0]  q_valid = '0, q_write = '0, q_sgn = '0, q_ack;
  logic [5:0]  q_width = '0;
  logic [95:0] q_addr = '0, q_wdata = '0;
  logic [31:0] q_rdata, q_dout = '0, q_adr, q_din;
  logic        q_busy, q_ready = 1'b0, q_we, q_re, q_msgn;
  logic [1:0]  q_wid;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        f_err, q_err;
`endif

  mem_access_ctrl #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .MAX_WAIT(4)) u_fix (
    .clk(clk), .reset_n(reset_n),
    .req_valid(f_valid), .req_write(f_write), .req_signed(f_sgn), .req_width(f_width),
    .req_addr(f_addr), .req_wdata(f_wdata), .req_ack(f_ack), .rsp_rdata(f_rdata),
    .busy(f_busy), .mmu_mem_ready(f_ready), .mmu_data_out(f_dout),
    .mmu_write_enable(f_we), .mmu_read_enable(f_re), .mmu_mem_signed_read(f_msgn),
    .mmu_mem_data_width(f_wid), .mmu_address(f_adr), .mmu_data_in(f_din)
`ifdef MEM_ACCESS_TIMEOUT_EN
    , .rsp_err(f_err)
`endif
  );

  mem_access_ctrl #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .MAX_WAIT(64)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req_valid(q_valid), .req_write(q_write), .req_signed(q_sgn), .req_width(q_width),
    .req_addr(q_addr), .req_wdata(q_wdata), .req_ack(q_ack), .rsp_rdata(q_rdata),
    .busy(q_busy), .mmu_mem_ready(q_ready), .mmu_data_out(q_dout),
    .mmu_write_enable(q_we), .mmu_read_enable(q_re), .mmu_mem_signed_read(q_msgn),
    .mmu_mem_data_width(q_wid), .mmu_address(q_adr), .mmu_data_in(q_din)
`ifdef MEM_ACCESS_TIMEOUT_EN
    , .rsp_err(q_err)
`endif
  );

  typedef struct {
    logic [1:0]  valid, write, sgn;
    logic [3:0]  width;
    logic [63:0] addr, wdata;
    int unsigned delay;
    logic [31:0] dout;
    logic [1:0]  e_ack;
    logic [31:0] e_rdata, e_addr, e_din;
    logic        e_we, e_re, e_sgn;
    logic [1:0]  e_wid;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rr_exp[4];
    int n;

    vt[0] = '{2'b10, 2'b00, 2'b00, 4'b1010, {32'h100, 32'h0}, 64'h0, 3, 32'hDEADBEEF,
              2'b10, 32'hDEADBEEF, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[1] = '{2'b01, 2'b01, 2'b00, 4'b1010, {32'h0, 32'h200}, {32'h0, 32'h12345678}, 0, 32'hAAAAAAAA,
              2'b01, 32'hDEADBEEF, 32'h200, 32'h12345678, 1'b1, 1'b0, 1'b0, 2'd2};
    vt[2] = '{2'b01, 2'b00, 2'b01, 4'b1000, {32'h0, 32'h3}, {32'h0, 32'h55}, 2, 32'hFFFFFF80,
              2'b01, 32'hFFFFFF80, 32'h3, 32'h0, 1'b0, 1'b1, 1'b1, 2'd0};
    vt[3] = '{2'b11, 2'b10, 2'b10, 4'b0110, {32'h20, 32'h10}, {32'hCAFE, 32'h99}, 1, 32'h11112222,
              2'b01, 32'h11112222, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[4] = '{2'b10, 2'b10, 2'b00, 4'b0110, {32'h44, 32'h0}, {32'hBEEF, 32'h0}, 1, 32'h77777777,
              2'b10, 32'h11112222, 32'h44, 32'hBEEF, 1'b1, 1'b0, 1'b0, 2'd1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", f_busy, 0);
    chk("rst_ack", f_ack, 0);
    chk("rst_en", {f_we, f_re}, 0);
    chk("rst_addr", f_adr, 0);
    chk("rst_rdata", f_rdata, 0);
    #3 reset_n = 1'b1;
    tick();
    chk("idle_busy", f_busy, 0);

    // table-driven single transactions on the fixed-priority instance
    for (int i = 0; i < 5; i++) begin
      f_valid = vt[i].valid; f_write = vt[i].write; f_sgn = vt[i].sgn;
      f_width = vt[i].width; f_addr = vt[i].addr; f_wdata = vt[i].wdata;
      f_ready = 1'b0;
      tick();
      chk($sformatf("v%0d_busy", i), f_busy, 1);
      chk($sformatf("v%0d_we", i), f_we, vt[i].e_we);
      chk($sformatf("v%0d_re", i), f_re, vt[i].e_re);
      chk($sformatf("v%0d_sgn", i), f_msgn, vt[i].e_sgn);
      chk($sformatf("v%0d_wid", i), f_wid, vt[i].e_wid);
      chk($sformatf("v%0d_addr", i), f_adr, vt[i].e_addr);
      chk($sformatf("v%0d_din", i), f_din, vt[i].e_din);
      for (int unsigned d = 0; d < vt[i].delay; d++) begin
        tick();
        chk($sformatf("v%0d_hold_addr", i), f_adr, vt[i].e_addr);
        chk($sformatf("v%0d_noack", i), f_ack, 0);
      end
      f_ready = 1'b1; f_dout = vt[i].dout;
      tick();
      chk($sformatf("v%0d_ack", i), f_ack, vt[i].e_ack);
      chk($sformatf("v%0d_rdata", i), f_rdata, vt[i].e_rdata);
      chk($sformatf("v%0d_done_en", i), {f_we, f_re}, 0);
      f_ready = 1'b0; f_valid = '0; f_dout = 32'h5A5A5A5A;
      tick();
      chk($sformatf("v%0d_ack_clr", i), f_ack, 0);
      chk($sformatf("v%0d_idle", i), f_busy, 0);
      chk($sformatf("v%0d_rdata_hold", i), f_rdata, vt[i].e_rdata);
    end

    // simultaneous ch0 store / ch1 load, then ch1; ch1 fields change mid-access
    f_valid = 2'b11; f_write = 2'b01; f_sgn = 2'b00; f_width = 4'b1010;
    f_addr = {32'h300, 32'h400}; f_wdata = {32'h0, 32'hA5A5A5A5}; f_ready = 1'b0;
    tick();
    chk("pri_we", f_we, 1);
    chk("pri_addr", f_adr, 32'h400);
    chk("pri_din", f_din, 32'hA5A5A5A5);
    f_ready = 1'b1;
    tick();
    chk("pri_ack0", f_ack, 2'b01);
    f_valid = 2'b10; f_ready = 1'b0;
    tick();
    tick();
    chk("pri_ch1_re", f_re, 1);
    chk("pri_ch1_addr", f_adr, 32'h300);
    chk("pri_ch1_din", f_din, 32'h0);
    f_addr = {32'h999, 32'h400};
    tick();
    chk("pri_latched_addr", f_adr, 32'h300);
    f_ready = 1'b1; f_dout = 32'h0BADF00D;
    tick();
    chk("pri_ack1", f_ack, 2'b10);
    chk("pri_rdata", f_rdata, 32'h0BADF00D);
    f_valid = '0; f_ready = 1'b0;
    tick();

    // round-robin, all three channels requesting continuously
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    q_valid = 3'b111; q_ready = 1'b1; q_width = 6'b101010; q_dout = 32'h0C0C0C0C;
    q_addr = {32'h30, 32'h20, 32'h10};
    n = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      tick();
      if (q_ack != 3'b000) begin
        chk($sformatf("rr_grant%0d", n), q_ack, rr_exp[n]);
        n++;
      end
    end
    chk("rr_grant_count", n, 4);
    q_valid = '0; q_ready = 1'b0;
    tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
    // timeout with MAX_WAIT = 4, ready never asserted
    f_valid = 2'b01; f_write = 2'b00; f_addr = {32'h0, 32'h500}; f_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("to_noack_early", f_ack, 0);
    end
    chk("to_ack", f_ack, 2'b01);
    chk("to_err", f_err, 1);
    chk("to_rdata", f_rdata, 0);
    f_valid = '0;
    tick();
    chk("to_err_clr", f_err, 0);
    f_valid = 2'b01; f_addr = {32'h0, 32'h600};
    tick();
    f_ready = 1'b1; f_dout = 32'h12121212;
    tick();
    chk("to_next_ack", f_ack, 2'b01);
    chk("to_next_rdata", f_rdata, 32'h12121212);
    chk("to_next_err", f_err, 0);
    f_valid = '0; f_ready = 1'b0;
    tick();
`endif

    // asynchronous reset in the middle of a ch1 load
    f_valid = 2'b10; f_write = 2'b00; f_addr = {32'h100, 32'h0}; f_ready = 1'b0;
    tick();
    chk("mid_busy", f_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", f_busy, 0);
    chk("arst_en", {f_we, f_re}, 0);
    chk("arst_addr", f_adr, 0);
    chk("arst_rdata", f_rdata, 0);
    chk("arst_ack", f_ack, 0);
    #2 reset_n = 1'b1; f_valid = '0;
    tick();
    chk("post_rst_busy", f_busy, 0);
    chk("post_rst_ack", f_ack, 0);
    tick();
    chk("post_rst_ack2", f_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
